mem_stage: RTL and testbench

Memory stage of the five-stage ARM pipeline, placed between the execute stage and the write-back stage. It registers the execute-stage results into the MEM/WB boundary and performs load/store accesses to a word-organised on-chip data memory. Each access takes a programmable multi-cycle latency, emulating an external SRAM. While an access is in flight, `ready` is low so the upstream stages freeze and hold their outputs. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory stage of the five-stage ARM pipeline (between execute and
//   write-back). Registers execute results into the MEM/WB boundary and
//   performs word loads/stores to an on-chip data memory. Every access
//   stalls for WAIT_CYCLES extra cycles to emulate an external SRAM; while
//   the access is in flight `ready` is low and upstream holds its outputs.
//   Non-memory instructions pass through with one cycle of latency.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous active-high reset
//   WB_en_in      : write-back enable from execute
//   mem_read_in   : load request
//   mem_write_in  : store request
//   ALU_res_in    : byte address for memory ops, otherwise the ALU result
//   val_Rm_in     : store data
//   dst_in        : destination register index
//   ready         : combinational, low = upstream must hold inputs stable
//   WB_en_out     : registered write-back enable (0 during access bubbles)
//   mem_read_out  : registered, selects mem_data_out in write-back
//   ALU_res_out   : registered ALU result
//   mem_data_out  : registered load data
//   dst_out       : registered destination register index
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 4,
    parameter int MEM_DEPTH      = 64,
    parameter int BASE_ADDR      = 1024,
    parameter int WAIT_CYCLES    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      WB_en_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic [WORD_WIDTH-1:0]     ALU_res_in,
    input  logic [WORD_WIDTH-1:0]     val_Rm_in,
    input  logic [REG_FILE_DEPTH-1:0] dst_in,
    output logic                      ready,
    output logic                      WB_en_out,
    output logic                      mem_read_out,
    output logic [WORD_WIDTH-1:0]     ALU_res_out,
    output logic [WORD_WIDTH-1:0]     mem_data_out,
    output logic [REG_FILE_DEPTH-1:0] dst_out
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            mem_req;
    logic            load_all;   // output register takes the new instruction
    logic            complete;   // memory access finishes at this edge
    logic [IDX_W-1:0] mem_index;

    logic [WORD_WIDTH-1:0] mem_array [MEM_DEPTH];

    assign mem_req = mem_read_in | mem_write_in;

    // Byte offset from the base, dropped to a word index. The cast keeps only
    // the low IDX_W bits, so out-of-range addresses alias modulo MEM_DEPTH.
    assign mem_index = IDX_W'((ALU_res_in - WORD_WIDTH'(BASE_ADDR)) >> 2);

    // -----------------------------------------------------------------------
    // FSM: next state, counter and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready      = 1'b0;
        load_all   = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    state_next = BUSY;
                    cnt_next   = 4'(WAIT_CYCLES - 1);
                end else begin
                    ready    = 1'b1;
                    load_all = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    ready      = 1'b1;
                    load_all   = 1'b1;
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // MEM/WB output register. When the instruction is not taken, a bubble is
    // inserted by clearing only the two control bits; the data fields hold.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_en_out    <= 1'b0;
            mem_read_out <= 1'b0;
            ALU_res_out  <= '0;
            mem_data_out <= '0;
            dst_out      <= '0;
        end else if (load_all) begin
            WB_en_out    <= WB_en_in;
            mem_read_out <= mem_read_in;
            ALU_res_out  <= ALU_res_in;
            dst_out      <= dst_in;
            // A combined read+write returns the data being written.
            if (complete && mem_read_in) begin
                mem_data_out <= mem_write_in ? val_Rm_in : mem_array[mem_index];
            end
        end else begin
            WB_en_out    <= 1'b0;
            mem_read_out <= 1'b0;
        end
    end

    // Data memory write port. Contents survive reset; a reset on the
    // completing edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && complete && mem_write_in) begin
            mem_array[mem_index] <= val_Rm_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int WW = 32;
    localparam int RW = 4;
    localparam int WAITC = 3;

    logic          clk;
    logic          rst;
    logic          WB_en_in;
    logic          mem_read_in;
    logic          mem_write_in;
    logic [WW-1:0] ALU_res_in;
    logic [WW-1:0] val_Rm_in;
    logic [RW-1:0] dst_in;
    logic          ready;
    logic          WB_en_out;
    logic          mem_read_out;
    logic [WW-1:0] ALU_res_out;
    logic [WW-1:0] mem_data_out;
    logic [RW-1:0] dst_out;

    int n_vec;
    int n_err;

    mem_stage #(
        .WORD_WIDTH    (WW),
        .REG_FILE_DEPTH(RW),
        .MEM_DEPTH     (64),
        .BASE_ADDR     (1024),
        .WAIT_CYCLES   (WAITC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .WB_en_in    (WB_en_in),
        .mem_read_in (mem_read_in),
        .mem_write_in(mem_write_in),
        .ALU_res_in  (ALU_res_in),
        .val_Rm_in   (val_Rm_in),
        .dst_in      (dst_in),
        .ready       (ready),
        .WB_en_out   (WB_en_out),
        .mem_read_out(mem_read_out),
        .ALU_res_out (ALU_res_out),
        .mem_data_out(mem_data_out),
        .dst_out     (dst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        WB_en_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    // Presents one memory op and clocks until it completes. Returns the number
    // of cycles ready was low and how many stall cycles showed WB_en_out high.
    task automatic do_access(input logic rd, input logic wr, input logic wb,
                             input logic [WW-1:0] addr, input logic [WW-1:0] data,
                             input logic [RW-1:0] dst,
                             output int low_cycles, output int bubble_bad,
                             output int timed_out);
        logic r;
        low_cycles = 0;
        bubble_bad = 0;
        timed_out  = 1;
        WB_en_in     = wb;
        mem_read_in  = rd;
        mem_write_in = wr;
        ALU_res_in   = addr;
        val_Rm_in    = data;
        dst_in       = dst;
        for (int i = 0; i < 40; i++) begin
            #1;
            r = ready;
            if (!r) low_cycles++;
            @(posedge clk);
            #1;
            if (r) begin
                timed_out = 0;
                break;
            end
            if (WB_en_out !== 1'b0) bubble_bad++;
        end
        drive_nop();
    endtask

    task automatic test_reset();
        drive_nop();
        ALU_res_in = 32'h0;
        val_Rm_in  = 32'h0;
        dst_in     = 4'h0;
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({WB_en_out, mem_read_out, ALU_res_out, mem_data_out, dst_out} !== '0) begin
            $display("FAIL reset_outputs: got wb=%b rd=%b alu=%h md=%h dst=%h, expected all 0",
                     WB_en_out, mem_read_out, ALU_res_out, mem_data_out, dst_out);
            n_err++;
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b expected 1", ready);
            n_err++;
        end
        $display("test_reset done");
    endtask

    task automatic test_pass_through();
        WB_en_in   = 1'b1;
        dst_in     = 4'd5;
        ALU_res_in = 32'h12;
        #1;
        n_vec++;
        if (ready !== 1'b1) begin
            $display("FAIL pass_ready: got %b expected 1", ready);
            n_err++;
        end
        tick();
        n_vec++;
        if (WB_en_out !== 1'b1 || dst_out !== 4'd5 || ALU_res_out !== 32'h12 || mem_read_out !== 1'b0) begin
            $display("FAIL pass_out: got wb=%b dst=%0d alu=%h rd=%b, expected wb=1 dst=5 alu=12 rd=0",
                     WB_en_out, dst_out, ALU_res_out, mem_read_out);
            n_err++;
        end
        // Back-to-back pass-through: second op on the very next cycle.
        dst_in     = 4'd9;
        ALU_res_in = 32'h3456;
        tick();
        n_vec++;
        if (WB_en_out !== 1'b1 || dst_out !== 4'd9 || ALU_res_out !== 32'h3456) begin
            $display("FAIL pass_b2b: got wb=%b dst=%0d alu=%h, expected wb=1 dst=9 alu=3456",
                     WB_en_out, dst_out, ALU_res_out);
            n_err++;
        end
        drive_nop();
        tick();
        n_vec++;
        if (WB_en_out !== 1'b0) begin
            $display("FAIL pass_nop: got wb=%b expected 0", WB_en_out);
            n_err++;
        end
        $display("test_pass_through done");
    endtask

    task automatic test_store_load();
        int lc, bb, to;
        do_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0, lc, bb, to);
        n_vec++;
        if (to != 0 || lc != WAITC || bb != 0) begin
            $display("FAIL store_wait: got low=%0d bubbles_bad=%0d timeout=%0d, expected low=3 0 0", lc, bb, to);
            n_err++;
        end
        do_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd3, lc, bb, to);
        n_vec++;
        if (to != 0 || lc != WAITC || bb != 0) begin
            $display("FAIL load_wait: got low=%0d bubbles_bad=%0d timeout=%0d, expected low=3 0 0", lc, bb, to);
            n_err++;
        end
        n_vec++;
        if (mem_data_out !== 32'hDEADBEEF || mem_read_out !== 1'b1 || dst_out !== 4'd3 || WB_en_out !== 1'b1) begin
            $display("FAIL load_data: got md=%h rd=%b dst=%0d wb=%b, expected deadbeef 1 3 1",
                     mem_data_out, mem_read_out, dst_out, WB_en_out);
            n_err++;
        end
        // Load data must hold across a following non-memory op.
        WB_en_in   = 1'b1;
        ALU_res_in = 32'h77;
        tick();
        drive_nop();
        n_vec++;
        if (mem_data_out !== 32'hDEADBEEF || mem_read_out !== 1'b0 || ALU_res_out !== 32'h77) begin
            $display("FAIL load_hold: got md=%h rd=%b alu=%h, expected deadbeef 0 77",
                     mem_data_out, mem_read_out, ALU_res_out);
            n_err++;
        end
        $display("test_store_load done");
    endtask

    task automatic test_alias();
        int lc, bb, to;
        do_access(1'b0, 1'b1, 1'b0, 32'd1280, 32'h11, 4'd0, lc, bb, to);
        do_access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 4'd1, lc, bb, to);
        n_vec++;
        if (to != 0 || mem_data_out !== 32'h11) begin
            $display("FAIL alias_1024: got md=%h timeout=%0d expected 11", mem_data_out, to);
            n_err++;
        end
        // Store something else into word 1 so a byte-offset bug would show up.
        do_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h22, 4'd0, lc, bb, to);
        do_access(1'b1, 1'b0, 1'b1, 32'd1027, 32'h0, 4'd1, lc, bb, to);
        n_vec++;
        if (to != 0 || mem_data_out !== 32'h11) begin
            $display("FAIL alias_1027: got md=%h timeout=%0d expected 11", mem_data_out, to);
            n_err++;
        end
        $display("test_alias done");
    endtask

    task automatic test_reset_mid_store();
        int lc, bb, to;
        do_access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h77, 4'd0, lc, bb, to);
        // Leave the output register holding non-zero values before reset.
        WB_en_in = 1'b1; ALU_res_in = 32'h99; dst_in = 4'd7;
        tick();
        // Store 0x55 to 1032, reset when cnt==1.
        WB_en_in = 1'b0; mem_write_in = 1'b1; ALU_res_in = 32'd1032; val_Rm_in = 32'h55;
        tick();            // cnt=2
        tick();            // cnt=1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_nop();
        #1;
        n_vec++;
        if ({WB_en_out, mem_read_out, ALU_res_out, mem_data_out, dst_out} !== '0 || ready !== 1'b1) begin
            $display("FAIL rst_mid_outputs: got wb=%b rd=%b alu=%h md=%h dst=%h rdy=%b, expected zeros rdy=1",
                     WB_en_out, mem_read_out, ALU_res_out, mem_data_out, dst_out, ready);
            n_err++;
        end
        // Reset on the completing edge (cnt==0) must also block the write.
        mem_write_in = 1'b1; ALU_res_in = 32'd1032; val_Rm_in = 32'h66;
        tick(); tick(); tick();   // cnt 2,1,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_nop();
        do_access(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd2, lc, bb, to);
        n_vec++;
        if (to != 0 || lc != WAITC || mem_data_out !== 32'h77) begin
            $display("FAIL rst_mid_load: got md=%h low=%0d timeout=%0d, expected 77 low=3", mem_data_out, lc, to);
            n_err++;
        end
        $display("test_reset_mid_store done");
    endtask

    task automatic test_read_write();
        int lc, bb, to;
        do_access(1'b1, 1'b1, 1'b1, 32'd1036, 32'hA5A5, 4'd6, lc, bb, to);
        n_vec++;
        if (to != 0 || lc != WAITC || mem_data_out !== 32'hA5A5 || mem_read_out !== 1'b1) begin
            $display("FAIL rw_both: got md=%h rd=%b low=%0d timeout=%0d, expected a5a5 1 low=3",
                     mem_data_out, mem_read_out, lc, to);
            n_err++;
        end
        do_access(1'b1, 1'b0, 1'b1, 32'd1040, 32'h0, 4'd6, lc, bb, to);  // disturb mem_data_out
        do_access(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0, 4'd6, lc, bb, to);
        n_vec++;
        if (to != 0 || mem_data_out !== 32'hA5A5) begin
            $display("FAIL rw_reload: got md=%h timeout=%0d expected a5a5", mem_data_out, to);
            n_err++;
        end
        $display("test_read_write done");
    endtask

    task automatic test_mixed_stream();
        logic [RW-1:0] dsts [3];
        logic [WW-1:0] alus [3];
        logic          rds  [3];
        logic [RW-1:0] seen [$];
        int  idx;
        int  pulses;
        logic r;
        dsts = '{4'd1, 4'd2, 4'd4};
        alus = '{32'h100, 32'd1024, 32'h300};
        rds  = '{1'b0, 1'b1, 1'b0};
        idx = 0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 3) begin
                WB_en_in = 1'b1; mem_read_in = rds[idx]; mem_write_in = 1'b0;
                ALU_res_in = alus[idx]; dst_in = dsts[idx];
            end else begin
                drive_nop();
            end
            #1;
            r = ready;
            tick();
            if (WB_en_out === 1'b1) begin
                pulses++;
                seen.push_back(dst_out);
                if (dst_out === 4'd2) begin
                    n_vec++;
                    if (mem_read_out !== 1'b1 || mem_data_out !== 32'h11 || ALU_res_out !== 32'd1024) begin
                        $display("FAIL mix_load: got rd=%b md=%h alu=%h, expected 1 11 400",
                                 mem_read_out, mem_data_out, ALU_res_out);
                        n_err++;
                    end
                end
            end
            if (r && idx < 3) idx++;
        end
        drive_nop();
        n_vec++;
        if (pulses != 3 || seen.size() != 3) begin
            $display("FAIL mix_count: got %0d pulses expected 3", pulses);
            n_err++;
        end else begin
            n_vec++;
            if (seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd4) begin
                $display("FAIL mix_order: got %0d,%0d,%0d expected 1,2,4", seen[0], seen[1], seen[2]);
                n_err++;
            end
        end
        $display("test_mixed_stream done");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive_nop();
        ALU_res_in = '0;
        val_Rm_in  = '0;
        dst_in     = '0;
        #2;
        test_reset();
        test_pass_through();
        test_store_load();
        test_alias();
        test_reset_mid_store();
        test_read_write();
        test_mixed_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
